mux_scan_sequencer: RTL and testbench

//  Upstream controller for a 4:1 mux stage (i0..i3, sel[1:0], out). Drives sel through

---
 rtl/mux_scan_sequencer.sv | 79 +++++++
 tb/tb_mux_scan_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps a 4:1 mux select through channels 0..3, samples each after SETTLE cycles, and hands the 4-bit frame out on valid/ready.
// Optional macro SCAN_PARITY_EN adds a registered frame_par output holding the XOR of the completed frame.
module mux_scan_sequencer #(
    parameter int SETTLE     = 1,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [1:0] sel,
    input  logic       mux_out,
    output logic       busy,
    output logic [3:0] frame,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic [7:0] frame_cnt
`ifdef SCAN_PARITY_EN
    ,
    output logic       frame_par
`endif
);
    localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
    state_t        state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sel         <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            frame       <= '0;
            frame_valid <= 1'b0;
            frame_cnt   <= '0;
`ifdef SCAN_PARITY_EN
            frame_par   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= SCAN;
                    busy  <= 1'b1;
                    sel   <= '0;
                    cnt   <= '0;
                end
                SCAN: if (cnt == LAST) begin
                    frame[sel] <= mux_out;
                    cnt        <= '0;
                    if (sel == 2'd3) begin
                        state       <= HOLD;
                        busy        <= 1'b0;
                        frame_valid <= 1'b1;
                        sel         <= '0;
`ifdef SCAN_PARITY_EN
                        // the last bit is still in flight, so fold it in directly
                        frame_par   <= ^{mux_out, frame[2:0]};
`endif
                    end else begin
                        sel <= sel + 2'd1;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
                HOLD: if (frame_ready) begin
                    frame_valid <= 1'b0;
                    frame_cnt   <= frame_cnt + 8'd1;
                    state       <= CONTINUOUS ? SCAN : IDLE;
                    busy        <= CONTINUOUS;
                    sel         <= '0;
                    cnt         <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: directed table-driven checks of mux_scan_sequencer in three configurations.
module tb_mux_scan_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start1, ready1, mux1, busy1, valid1, par1;
    logic [1:0] sel1;
    logic [3:0] frame1, in1;
    logic [7:0] cnt1;
    logic       start3, ready3, mux3, busy3, valid3, par3;
    logic [1:0] sel3;
    logic [3:0] frame3, in3;
    logic [7:0] cnt3;
    logic       startc, readyc, muxc, busyc, validc, parc;
    logic [1:0] selc;
    logic [3:0] framec, inc;
    logic [7:0] cntc;

    assign mux1 = in1[sel1];
    assign mux3 = in3[sel3];
    assign muxc = inc[selc];

    mux_scan_sequencer #(.SETTLE(1), .CONTINUOUS(1'b0)) u1 (
        .clk(clk), .rst(rst), .start(start1), .sel(sel1), .mux_out(mux1), .busy(busy1),
        .frame(frame1), .frame_valid(valid1), .frame_ready(ready1), .frame_cnt(cnt1)
`ifdef SCAN_PARITY_EN
        , .frame_par(par1)
`endif
    );
    mux_scan_sequencer #(.SETTLE(3), .CONTINUOUS(1'b0)) u3 (
        .clk(clk), .rst(rst), .start(start3), .sel(sel3), .mux_out(mux3), .busy(busy3),
        .frame(frame3), .frame_valid(valid3), .frame_ready(ready3), .frame_cnt(cnt3)
`ifdef SCAN_PARITY_EN
        , .frame_par(par3)
`endif
    );
    mux_scan_sequencer #(.SETTLE(2), .CONTINUOUS(1'b1)) uc (
        .clk(clk), .rst(rst), .start(startc), .sel(selc), .mux_out(muxc), .busy(busyc),
        .frame(framec), .frame_valid(validc), .frame_ready(readyc), .frame_cnt(cntc)
`ifdef SCAN_PARITY_EN
        , .frame_par(parc)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_par(input string name, input logic act, input logic exp);
`ifdef SCAN_PARITY_EN
        chk(name, {31'd0, act}, {31'd0, exp});
`endif
    endtask

    task automatic run1(input logic [3:0] pat, output int lat);
        in1 = pat;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        lat = 0;
        while (!valid1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        logic [3:0] in;
        logic [3:0] frame;
        logic       par;
    } vec_t;
    vec_t vt[7];

    logic [3:0] pc[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int lat, bad;
        vt[0] = '{4'b0000, 4'b0000, 1'b0};
        vt[1] = '{4'b1111, 4'b1111, 1'b0};
        vt[2] = '{4'b0001, 4'b0001, 1'b1};
        vt[3] = '{4'b1000, 4'b1000, 1'b1};
        vt[4] = '{4'b0110, 4'b0110, 1'b0};
        vt[5] = '{4'b1010, 4'b1010, 1'b0};
        vt[6] = '{4'b0111, 4'b0111, 1'b1};
        pc[0] = 4'b1101; pc[1] = 4'b0010; pc[2] = 4'b1111; pc[3] = 4'b0000; pc[4] = 4'b1001;
        {start1, ready1, start3, ready3, startc, readyc} = '0;
        in1 = '0; in3 = '0; inc = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_sel", sel1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_valid", valid1, 0);
        chk("rst_frame", frame1, 0);
        chk("rst_cnt", cnt1, 0);
        chk_par("rst_par", par1, 1'b0);

        // scan sequence with SETTLE=1
        in1 = 4'b1101;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("t1_sel0", sel1, 0);
        chk("t1_busy", busy1, 1);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk("t1_sel", sel1, k);
            chk("t1_nvalid", valid1, 0);
        end
        @(negedge clk);
        chk("t1_valid", valid1, 1);
        chk("t1_frame", frame1, 4'b1101);
        chk("t1_busy_hold", busy1, 0);
        chk("t1_sel_hold", sel1, 0);
        chk_par("t1_par", par1, 1'b1);

        // backpressure in HOLD; start is not queued
        start1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start1 = 1'b0;
            chk("t3_valid", valid1, 1);
            chk("t3_frame", frame1, 4'b1101);
            chk("t3_cnt", cnt1, 0);
        end
        ready1 = 1'b1;
        @(negedge clk);
        ready1 = 1'b0;
        chk("t3_drop", valid1, 0);
        chk("t3_cnt1", cnt1, 1);
        repeat (3) @(negedge clk);
        chk("t3_idle", busy1, 0);
        ready1 = 1'b1;
        repeat (2) @(negedge clk);
        ready1 = 1'b0;
        chk("t3_ready_noval", cnt1, 1);

        for (int i = 0; i < 7; i++) begin
            run1(vt[i].in, lat);
            chk("tv_lat", lat, 4);
            chk("tv_frame", frame1, vt[i].frame);
            chk_par("tv_par", par1, vt[i].par);
            ready1 = 1'b1;
            @(negedge clk);
            ready1 = 1'b0;
            chk("tv_drop", valid1, 0);
            chk("tv_cnt", cnt1, 2 + i);
        end

        // SETTLE=3 with a start pulse mid-scan
        in3 = 4'b1101;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k == 5) start3 = 1'b1;
            if (k == 6) start3 = 1'b0;
            chk("t2_sel", sel3, k / 3);
            chk("t2_nvalid", valid3, 0);
            chk("t2_busy", busy3, 1);
            @(negedge clk);
        end
        chk("t2_valid", valid3, 1);
        chk("t2_frame", frame3, 4'b1101);
        chk_par("t2_par", par3, 1'b1);
        ready3 = 1'b1;
        @(negedge clk);
        ready3 = 1'b0;
        chk("t2_drop", valid3, 0);
        chk("t2_cnt", cnt3, 1);

        // continuous mode, SETTLE=2, ready tied high
        readyc = 1'b1;
        inc = pc[0];
        startc = 1'b1;
        @(negedge clk);
        startc = 1'b0;
        for (int f = 0; f < 5; f++) begin
            lat = 0;
            if (f > 0) begin
                @(negedge clk);
                lat = 1;
            end
            while (!validc && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            chk("t4_period", lat, f == 0 ? 8 : 9);
            chk("t4_frame", framec, pc[f]);
            chk("t4_cnt", cntc, f);
            chk_par("t4_par", parc, ^pc[f]);
            if (f < 4) inc = pc[f + 1];
        end

        // async reset mid-scan at sel==2
        in1 = 4'b1101;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_sel2", sel1, 2);
        #2 rst = 1'b1;
        #1;
        chk("t5_sel", sel1, 0);
        chk("t5_busy", busy1, 0);
        chk("t5_valid", valid1, 0);
        chk("t5_frame", frame1, 0);
        chk("t5_cnt", cnt1, 0);
        chk("t5_cntc", cntc, 0);
        @(negedge clk);
        rst = 1'b0;
        readyc = 1'b0;
        @(negedge clk);
        run1(4'b0110, lat);
        chk("t5_lat", lat, 4);
        chk("t5_refr", frame1, 4'b0110);
        ready1 = 1'b1;
        @(negedge clk);
        chk("t5_cnt1", cnt1, 1);

        // frame counter wrap with ready held high
        bad = 0;
        for (int j = 0; j < 254; j++) begin
            run1(4'(j), lat);
            if (lat != 4) bad++;
            @(negedge clk);
        end
        chk("t6_lat_all", bad, 0);
        chk("t6_cnt255", cnt1, 255);
        run1(4'b1011, lat);
        chk("t6_frame", frame1, 4'b1011);
        @(negedge clk);
        chk("t6_wrap", cnt1, 0);
        chk("t6_drop", valid1, 0);
        run1(4'b0100, lat);
        chk("t6_lat_after", lat, 4);
        chk("t6_frame_after", frame1, 4'b0100);
        @(negedge clk);
        chk("t6_cnt_after", cnt1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
